// File: rtl/riscv_pkg.sv
// Shared types for the ID/EX operand stage: ALU opcodes, the registered EX slot and x0.
// Purely declarative; no latency or flow control of its own.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int OP_W  = 4;
    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [OP_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_BNE = 4'b0011,
        ALU_OR  = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_BGE = 4'b0110,
        ALU_BLT = 4'b0111,
        ALU_EQ  = 4'b1000
    } alu_op_e;

    // An all-zero id_ex_t is a bubble: not valid, no write-back, no load.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic             alu_src;
        logic [OP_W-1:0]  alu_op;
        logic             mem_read;
        logic             reg_write;
    } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand forwarding select: MEM result over WB result over register-file data; x0 never forwarded.
// Latency: combinational. Backpressure: none.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_ADDR_W = REG_W
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [DATA_WIDTH-1:0] i_rs_data,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_mem_reg_write,
    input  logic [DATA_WIDTH-1:0] i_mem_result,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic                  i_wb_reg_write,
    input  logic [DATA_WIDTH-1:0] i_wb_result,
    output logic [DATA_WIDTH-1:0] o_operand
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_reg_write && (i_mem_rd != REG_ZERO) && (i_mem_rd == i_rs);
    assign w_wb_hit  = i_wb_reg_write  && (i_wb_rd  != REG_ZERO) && (i_wb_rd  == i_rs);

    always_comb begin
        o_operand = i_rs_data;
        if (w_mem_hit) begin
            o_operand = i_mem_result;
        end else if (w_wb_hit) begin
            o_operand = i_wb_result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with MEM/WB forwarding, load-use stall/bubble insertion and flush; counts bubbles.
// Latency: 1 cycle ID->SrcA/SrcB/Operation. Backpressure: id_stall holds ID for one cycle per load-use bubble.
module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = XLEN,
    parameter int OPCODE_LENGTH = OP_W,
    parameter int REG_ADDR_W    = REG_W,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     id_alu_src,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_mem_read,
    input  logic                     id_reg_write,
    input  logic                     flush,
    input  logic [REG_ADDR_W-1:0]    mem_rd,
    input  logic                     mem_reg_write,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic [REG_ADDR_W-1:0]    wb_rd,
    input  logic                     wb_reg_write,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic                     id_stall,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_mem_read,
    output logic                     ex_reg_write,
    output logic [DATA_WIDTH-1:0]    ex_rs2_fwd,
    output logic [CNT_WIDTH-1:0]     bubble_count
);

    id_ex_t                  r_ex;
    id_ex_t                  w_ex_next;
    logic [CNT_WIDTH-1:0]    r_bubble_cnt;
    logic                    w_hazard;
    logic [DATA_WIDTH-1:0]   w_rs1_fwd;
    logic [DATA_WIDTH-1:0]   w_rs2_fwd;

    // Load in EX whose destination is read by the instruction in ID.
    assign w_hazard = id_valid && r_ex.valid && r_ex.mem_read && (r_ex.rd != REG_ZERO)
                      && ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2));
    assign id_stall = w_hazard && !flush;

    always_comb begin
        w_ex_next = '0;
        if (!flush && !w_hazard) begin
            w_ex_next.valid     = id_valid;
            w_ex_next.rs1       = id_rs1;
            w_ex_next.rs2       = id_rs2;
            w_ex_next.rd        = id_rd;
            w_ex_next.rs1_data  = id_rs1_data;
            w_ex_next.rs2_data  = id_rs2_data;
            w_ex_next.imm       = id_imm;
            w_ex_next.alu_src   = id_alu_src;
            w_ex_next.alu_op    = id_alu_op;
            w_ex_next.mem_read  = id_mem_read;
            w_ex_next.reg_write = id_reg_write;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex         <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_ex <= w_ex_next;
            // Only load-use bubbles are counted; the counter sticks at all-ones.
            if (id_stall && (r_bubble_cnt != {CNT_WIDTH{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .i_rs            (r_ex.rs1),
        .i_rs_data       (r_ex.rs1_data),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_result    (mem_result),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_result     (wb_result),
        .o_operand       (w_rs1_fwd)
    );

    fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .i_rs            (r_ex.rs2),
        .i_rs_data       (r_ex.rs2_data),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_result    (mem_result),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_result     (wb_result),
        .o_operand       (w_rs2_fwd)
    );

    assign ex_valid     = r_ex.valid;
    assign SrcA         = w_rs1_fwd;
    assign SrcB         = r_ex.alu_src ? r_ex.imm : w_rs2_fwd;
    assign Operation    = r_ex.alu_op;
    assign ex_rd        = r_ex.rd;
    assign ex_mem_read  = r_ex.mem_read;
    assign ex_reg_write = r_ex.reg_write;
    assign ex_rs2_fwd   = w_rs2_fwd;
    assign bubble_count = r_bubble_cnt;

endmodule
